// File: rtl/switch_cfg_pkg.sv
// Shared field map, sequencer states and decoded configuration record for the
// switch configuration sequencer.
package switch_cfg_pkg;

  localparam int SW_W           = 16;
  localparam int RAW_BIT        = 0;
  localparam int MUTE_BIT       = 3;
  localparam int VOL_BIT        = 4;
  localparam int SONG_LSB       = 9;
  localparam int SONG_MSB       = 11;
  localparam int ADC_METHOD_BIT = 13;
  localparam int ADC_SEL_LSB    = 14;
  localparam int ADC_SEL_MSB    = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STOP  = 2'd1,
    GAP   = 2'd2,
    START = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [1:0] adc_sel;
    logic       adc_method;
    logic [2:0] song;
    logic       volume;
    logic       mute;
    logic       raw;
  } cfg_t;

  function automatic cfg_t decode_cfg(input logic [SW_W-1:0] sw);
    cfg_t c;
    c.adc_sel    = sw[ADC_SEL_MSB:ADC_SEL_LSB];
    c.adc_method = sw[ADC_METHOD_BIT];
    c.song       = sw[SONG_MSB:SONG_LSB];
    c.volume     = sw[VOL_BIT];
    c.mute       = sw[MUTE_BIT];
    c.raw        = sw[RAW_BIT];
    return c;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a whole-vector debouncer; emits the committed
// vector together with a one-cycle commit strobe.
module switch_debouncer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             commit
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [WIDTH-1:0] meta_q, sync_q, cand_q, dout_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit_q, commit_d;

  // Commit exactly once, on the cycle the stable count reaches its saturation value.
  always_comb begin
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    if (sync_q != cand_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d    = cnt_q + 1'b1;
      commit_d = (cnt_q == CNT_PRE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      meta_q   <= din;
      sync_q   <= meta_q;
      cand_q   <= sync_q;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      if (commit_d) dout_q <= cand_q;
    end
  end

  assign dout   = dout_q;
  assign commit = commit_q;

endmodule

// File: rtl/switch_config_sequencer.sv
// Debounced switch configuration plus stop/gap/start song sequencer.
// Define AUTO_START_EN to force one start sequence on the first commit after reset.
module switch_config_sequencer
  import switch_cfg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GAP_CYCLES      = 100_000,
  parameter int ACK_TIMEOUT     = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] switches,
  input  logic        player_stop_ack,
  output logic        player_stop_req,
  output logic        player_start,
  output logic [2:0]  song_id,
  output logic        raw_data_display,
  output logic [1:0]  adc_select,
  output logic        adc_method,
  output logic        volume_control,
  output logic        buzzer_mute,
  output logic        adc_reconfig,
  output logic        stop_timeout
);

  localparam int CNT_TOP = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  logic [SW_W-1:0] sw_vec;
  logic            commit;
  cfg_t            cfg_w;
  logic            unused_sw;

  switch_debouncer #(
    .WIDTH          (SW_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (switches),
    .dout   (sw_vec),
    .commit (commit)
  );

  assign cfg_w     = decode_cfg(sw_vec);
  assign unused_sw = ^{sw_vec[12], sw_vec[8:5], sw_vec[2:1]};

  logic       raw_q, raw_d, vol_q, vol_d, mute_sw_q, mute_sw_d;
  logic [1:0] adc_sel_q, adc_sel_d;
  logic       adc_method_q, adc_method_d, reconfig_q, reconfig_d;

  always_comb begin
    raw_d        = raw_q;
    vol_d        = vol_q;
    mute_sw_d    = mute_sw_q;
    adc_sel_d    = adc_sel_q;
    adc_method_d = adc_method_q;
    reconfig_d   = 1'b0;
    if (commit) begin
      raw_d        = cfg_w.raw;
      vol_d        = cfg_w.volume;
      mute_sw_d    = cfg_w.mute;
      adc_sel_d    = cfg_w.adc_sel;
      adc_method_d = cfg_w.adc_method;
      reconfig_d   = {cfg_w.adc_sel, cfg_w.adc_method} != {adc_sel_q, adc_method_q};
    end
  end

  logic auto_go;
`ifdef AUTO_START_EN
  logic auto_pend_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    auto_pend_q <= 1'b1;
    else if (commit) auto_pend_q <= 1'b0;
  end
  assign auto_go = auto_pend_q & commit;
`else
  assign auto_go = 1'b0;
`endif

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       active_q, active_d, song_id_q, song_id_d;
  logic             timeout_q, timeout_d, mute_q, mute_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    active_d        = active_q;
    song_id_d       = song_id_q;
    timeout_d       = timeout_q;
    player_stop_req = 1'b0;
    player_start    = 1'b0;
    song_id         = song_id_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if ((cfg_w.song != active_q) || auto_go) state_d = STOP;
      end
      STOP: begin
        player_stop_req = 1'b1;
        if (player_stop_ack) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == ACK_LAST) begin
          state_d   = GAP;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        // The song is sampled here so changes made during STOP/GAP are honoured.
        player_start = 1'b1;
        song_id      = cfg_w.song;
        song_id_d    = cfg_w.song;
        active_d     = cfg_w.song;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mute_d = mute_sw_d | (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      active_q     <= '0;
      song_id_q    <= '0;
      timeout_q    <= 1'b0;
      mute_q       <= 1'b0;
      raw_q        <= 1'b0;
      vol_q        <= 1'b0;
      mute_sw_q    <= 1'b0;
      adc_sel_q    <= '0;
      adc_method_q <= 1'b0;
      reconfig_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      song_id_q    <= song_id_d;
      timeout_q    <= timeout_d;
      mute_q       <= mute_d;
      raw_q        <= raw_d;
      vol_q        <= vol_d;
      mute_sw_q    <= mute_sw_d;
      adc_sel_q    <= adc_sel_d;
      adc_method_q <= adc_method_d;
      reconfig_q   <= reconfig_d;
    end
  end

  assign raw_data_display = raw_q;
  assign adc_select       = adc_sel_q;
  assign adc_method       = adc_method_q;
  assign volume_control   = vol_q;
  assign buzzer_mute      = mute_q;
  assign adc_reconfig     = reconfig_q;
  assign stop_timeout     = timeout_q;

endmodule

// File: tb/tb_switch_config_sequencer.sv
// Scoreboard bench: stimulus pushes expected start/reconfig events, a negedge monitor
// pops and compares them against what the sequencer presents.
module tb_switch_config_sequencer;

  localparam int DEB  = 8;
  localparam int GAPC = 4;
  localparam int ACKT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] switches = '0;
  logic        player_stop_ack = 1'b0;
  logic        player_stop_req, player_start;
  logic [2:0]  song_id;
  logic        raw_data_display;
  logic [1:0]  adc_select;
  logic        adc_method, volume_control, buzzer_mute, adc_reconfig, stop_timeout;

  switch_config_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAPC),
    .ACK_TIMEOUT    (ACKT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .switches        (switches),
    .player_stop_ack (player_stop_ack),
    .player_stop_req (player_stop_req),
    .player_start    (player_start),
    .song_id         (song_id),
    .raw_data_display(raw_data_display),
    .adc_select      (adc_select),
    .adc_method      (adc_method),
    .volume_control  (volume_control),
    .buzzer_mute     (buzzer_mute),
    .adc_reconfig    (adc_reconfig),
    .stop_timeout    (stop_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int song;
    int stop_len;
    int tmo;
    int mute;
  } seq_exp_t;

  seq_exp_t seq_q[$];
  int       adc_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       ack_d = 1;
  int       m_song = 0, m_adc = 0, m_to = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Player model: ack rises once stop_req has been seen for ack_d cycles.
  int ack_seen = 0;
  always @(negedge clk) begin
    if (player_stop_req) begin
      player_stop_ack = (ack_seen >= ack_d);
      ack_seen++;
    end else begin
      player_stop_ack = 1'b0;
      ack_seen = 0;
    end
  end

  function automatic seq_exp_t mk_seq(input int song, input int d, input int tmo, input int mute);
    seq_exp_t e;
    e.song     = song;
    e.stop_len = (d >= ACKT) ? ACKT : d + 1;
    e.tmo      = tmo;
    e.mute     = mute;
    return e;
  endfunction

  // Monitor
  int       stop_cnt = 0, gap_cnt = 0, mute_err = 0, in_seq = 0, mute_next = -1;
  logic [2:0] prev_song = '0;
  seq_exp_t mon_e;
  int       adc_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      stop_cnt = 0; gap_cnt = 0; mute_err = 0; in_seq = 0; mute_next = -1;
      prev_song = song_id;
    end else begin
      if (mute_next >= 0) begin
        check("mute_after_start", int'(buzzer_mute), mute_next);
        mute_next = -1;
      end
      if (player_stop_req) begin
        stop_cnt++;
        in_seq = 1;
      end else if (in_seq != 0 && !player_start) begin
        gap_cnt++;
      end
      if (in_seq != 0 && !buzzer_mute) mute_err++;
      if (song_id != prev_song) check("song_id_change_without_start", int'(player_start), 1);
      prev_song = song_id;
      if (player_start) begin
        if (seq_q.size() == 0) begin
          check("unexpected_start_song", int'(song_id), -1);
        end else begin
          mon_e = seq_q.pop_front();
          check("start_song_id", int'(song_id), mon_e.song);
          check("stop_req_len", stop_cnt, mon_e.stop_len);
          check("gap_len", gap_cnt, GAPC);
          check("stop_timeout", int'(stop_timeout), mon_e.tmo);
          check("mute_forced_cycles_missing", mute_err, 0);
          mute_next = mon_e.mute;
        end
        stop_cnt = 0; gap_cnt = 0; mute_err = 0; in_seq = 0;
      end
      if (adc_reconfig) begin
        if (adc_q.size() == 0) begin
          check("unexpected_adc_reconfig", int'({adc_select, adc_method}), -1);
        end else begin
          adc_e = adc_q.pop_front();
          check("adc_fields_at_reconfig", int'({adc_select, adc_method}), adc_e);
        end
      end
    end
  end

  task automatic apply(input logic [15:0] sw, input int d);
    @(negedge clk);
    ack_d    = d;
    switches = sw;
    if (int'(sw[15:13]) != m_adc) begin
      adc_q.push_back(int'(sw[15:13]));
      m_adc = int'(sw[15:13]);
    end
    if (int'(sw[11:9]) != m_song) begin
      if (d >= ACKT) m_to = 1;
      seq_q.push_back(mk_seq(int'(sw[11:9]), d, m_to, int'(sw[3])));
      m_song = int'(sw[11:9]);
    end
    repeat (50) @(negedge clk);
  endtask

  int          d_tab[5] = '{0, 1, 2, 5, 30};
  logic [15:0] sw;
  int          lat, k, mute_seen;

  initial begin
    reset_n = 1'b0;
    ack_d   = 1;
`ifdef AUTO_START_EN
    seq_q.push_back(mk_seq(0, 1, 0, 0));
`endif
    #1;
    check("reset_outputs", int'({player_stop_req, player_start, song_id, raw_data_display, adc_select,
          adc_method, volume_control, buzzer_mute, adc_reconfig, stop_timeout}), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);

    // Bounce on the mute switch, then a clean level.
    mute_seen = 0;
    for (int i = 0; i < 10; i++) begin
      switches[3] = ~switches[3];
      repeat (3) begin
        @(negedge clk);
        if (buzzer_mute) mute_seen = 1;
      end
    end
    check("mute_during_bounce", mute_seen, 0);
    switches[3] = 1'b1;
    lat = 0;
    while (!buzzer_mute && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("mute_commit_latency", lat, 2 + DEB + 1);
    repeat (5) @(negedge clk);

    // Song 0->5 with ack, then 5->2 with no ack.
    sw = '0; sw[11:9] = 3'd5;
    apply(sw, 1);
    sw[11:9] = 3'd2;
    apply(sw, 99);

    // ADC fields 000->101, then volume only.
    sw[15:13] = 3'b101;
    apply(sw, 1);
    check("adc_select_value", int'(adc_select), 2);
    check("adc_method_value", int'(adc_method), 1);
    sw[4] = ~sw[4];
    apply(sw, 1);
    check("volume_value", int'(volume_control), int'(sw[4]));

    // Song 3 then 6 arriving while the sequencer sits in its gap.
    @(negedge clk);
    ack_d = 99;
    sw[11:9] = 3'd3;
    switches = sw;
    repeat (18) @(negedge clk);
    sw[11:9] = 3'd6;
    switches = sw;
    m_to = 1;
    seq_q.push_back(mk_seq(6, 99, 1, int'(sw[3])));
    m_song = 6;
    repeat (50) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      sw = 16'($urandom);
      apply(sw, d_tab[$urandom_range(0, 4)]);
      check("raw_display", int'(raw_data_display), int'(sw[0]));
    end

    // Reset in the middle of the gap.
    sw = switches;
    sw[11:9] = 3'(m_song + 1);
    @(negedge clk);
    ack_d = 99;
    switches = sw;
    k = 0;
    while (!player_stop_req && k < 100) begin @(negedge clk); k++; end
    while (player_stop_req && k < 100) begin @(negedge clk); k++; end
    check("reached_gap_before_reset", int'(k < 100), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("outputs_zero_in_reset", int'({player_stop_req, player_start, song_id, raw_data_display, adc_select,
          adc_method, volume_control, buzzer_mute, adc_reconfig, stop_timeout}), 0);
    seq_q.delete();
    adc_q.delete();
    m_song = 0; m_adc = 0; m_to = 0;
    switches = '0;
    ack_d = 1;
`ifdef AUTO_START_EN
    seq_q.push_back(mk_seq(0, 1, 0, 0));
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("stop_timeout_after_reset", int'(stop_timeout), 0);

    check("pending_starts", seq_q.size(), 0);
    check("pending_reconfigs", adc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

endmodule
